// File: rtl/patp_alu_seq.sv
// Registered PATP ALU with valid/ready handshake and z/c/n/v flags.
// Optional feature macro ALU_MUL_EN adds a multi-cycle shift-and-add multiply (func=111).
module patp_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v,
  output logic             busy
);

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready, and
  // out_valid/result/flags hold stable until that transfer.

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             accept;
  logic             idle;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;

  assign idle     = (state == S_IDLE);
  assign busy     = (state == S_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
  assign idle = 1'b1;
  assign busy = 1'b0;
`endif

  assign in_ready = idle && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ext carries one extra bit so carry and borrow fall out of bit WIDTH.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (func)
      3'b001: begin
        ext     = {1'b0, q} + (WIDTH+1)'(1);
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (q == MAX_POS);
      end
      3'b010: begin
        ext     = {1'b0, q} + {1'b0, p};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (q[WIDTH-1] == p[WIDTH-1]) && (ext[WIDTH-1] != q[WIDTH-1]);
      end
      3'b011: begin
        ext     = {1'b0, q} - (WIDTH+1)'(1);
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (q == MIN_NEG);
      end
      3'b100: begin
        ext     = {1'b0, q} - {1'b0, p};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (q[WIDTH-1] != p[WIDTH-1]) && (ext[WIDTH-1] != q[WIDTH-1]);
      end
      3'b101: alu_res = q & p;
      3'b110: alu_res = q ^ p;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      n         <= 1'b0;
      v         <= 1'b0;
`ifdef ALU_MUL_EN
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      if (state == S_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
        // Last multiplier bit: the counter reaches 0 on this edge.
        if (cnt == CNT_W'(1)) begin
          state     <= S_IDLE;
          out_valid <= 1'b1;
          result    <= acc_next[WIDTH-1:0];
          z         <= (acc_next[WIDTH-1:0] == '0);
          c         <= |acc_next[2*WIDTH-1:WIDTH];
          n         <= acc_next[WIDTH-1];
          v         <= 1'b0;
        end
      end else
`endif
      if (accept) begin
`ifdef ALU_MUL_EN
        if (func == 3'b111) begin
          state     <= S_MUL;
          cnt       <= CNT_W'(WIDTH);
          acc       <= '0;
          mcand     <= {{WIDTH{1'b0}}, p};
          mplier    <= q;
          out_valid <= 1'b0;
        end else
`endif
        begin
          out_valid <= 1'b1;
          result    <= alu_res;
          z         <= (alu_res == '0);
          c         <= alu_c;
          n         <= alu_res[WIDTH-1];
          v         <= alu_v;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_patp_alu_seq.sv
// Self-checking bench for patp_alu_seq: directed scenarios plus randomized traffic
// against an arithmetic reference model; multiply checks depend on ALU_MUL_EN.
module tb_patp_alu_seq;
  localparam int W = 8;
  localparam longint M = longint'(1) << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   func;
  logic [W-1:0] p;
  logic [W-1:0] q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         z, c, n, v;
  logic         busy;

  int vectors = 0;
  int errors  = 0;
  logic [W+3:0] exp_q[$];

  patp_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .p(p), .q(q), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z(z), .c(c), .n(n), .v(v), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic longint to_signed(input longint u);
    return (u >= M / 2) ? u - M : u;
  endfunction

  // Reference model: returns {result, z, c, n, v}.
  function automatic logic [W+3:0] model(input logic [2:0] f, input logic [W-1:0] mp,
                                         input logic [W-1:0] mq);
    longint uq, up, full, s;
    logic [W-1:0] r;
    logic cf, vf;
    uq = longint'(mq);
    up = longint'(mp);
    full = 0;
    cf = 1'b0;
    vf = 1'b0;
    case (f)
      3'd1: begin full = uq + 1;  cf = (full >= M); s = to_signed(uq) + 1; vf = (s >= M / 2); end
      3'd2: begin full = uq + up; cf = (full >= M); s = to_signed(uq) + to_signed(up);
                  vf = (s >= M / 2) || (s < -M / 2); end
      3'd3: begin full = uq - 1;  cf = (uq < 1);    s = to_signed(uq) - 1; vf = (s < -M / 2); end
      3'd4: begin full = uq - up; cf = (uq < up);   s = to_signed(uq) - to_signed(up);
                  vf = (s >= M / 2) || (s < -M / 2); end
      3'd5: full = uq & up;
      3'd6: full = uq ^ up;
`ifdef ALU_MUL_EN
      3'd7: begin full = uq * up; cf = (full >= M); end
`endif
      default: full = 0;
    endcase
    r = full[W-1:0];
    return {r, (r == '0), cf, r[W-1], vf};
  endfunction

  // Scoreboard: log accepts, compare each consumed result in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got %h expected none", {result, z, c, n, v});
        end else begin
          if ({result, z, c, n, v} !== exp_q[0]) begin
            errors++;
            $display("FAIL sb_result got %h expected %h", {result, z, c, n, v}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(func, p, q));
    end
  end

  task automatic op(input logic [2:0] f, input logic [W-1:0] pp, input logic [W-1:0] qq);
    int waited = 0;
    in_valid = 1'b1;
    func = f;
    p = pp;
    q = qq;
    #1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      vectors++; errors++;
      $display("FAIL op_accept_timeout got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; func = '0; p = '0; q = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, busy, result, z, c, n, v, in_ready} !== {2'b00, {W{1'b0}}, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got %b expected valid/busy/result/flags 0, in_ready 1",
               {out_valid, busy, result, z, c, n, v, in_ready});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    op(3'b010, 8'h01, 8'h7F);
    vectors++;
    if ({out_valid, result, z, c, n, v} !== {1'b1, 8'h80, 4'b0011}) begin
      errors++;
      $display("FAIL add_overflow got %h expected %h", {out_valid, result, z, c, n, v},
               {1'b1, 8'h80, 4'b0011});
    end
  endtask

  task automatic test_dec_inc_wrap();
    op(3'b011, 8'h00, 8'h00);
    vectors++;
    if ({result, z, c, n, v} !== {8'hFF, 4'b0110}) begin
      errors++;
      $display("FAIL dec_borrow got %h expected %h", {result, z, c, n, v}, {8'hFF, 4'b0110});
    end
    op(3'b001, 8'h00, 8'hFF);
    vectors++;
    if ({result, z, c, n, v} !== {8'h00, 4'b1100}) begin
      errors++;
      $display("FAIL inc_carry got %h expected %h", {result, z, c, n, v}, {8'h00, 4'b1100});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    op(3'b001, 8'h00, 8'h04);
    out_ready = 1'b0;
    in_valid = 1'b1; func = 3'b001; q = 8'h10; p = 8'h00;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready got %b expected 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, result} !== {1'b1, 8'h05}) begin
        errors++;
        $display("FAIL bp_hold got %h expected %h", {out_valid, result}, {1'b1, 8'h05});
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, result} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL bp_next_result got %h expected %h", {out_valid, result}, {1'b1, 8'h11});
    end
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      func = 3'($urandom_range(0, 6));
      p = W'($urandom);
      q = W'($urandom);
      e = model(func, p, q);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready got %b expected 1", in_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, result, z, c, n, v} !== {1'b1, e}) begin
        errors++;
        $display("FAIL b2b_result func=%0d got %h expected %h", func,
                 {out_valid, result, z, c, n, v}, {1'b1, e});
      end
    end
    in_valid = 1'b0;
  endtask

`ifdef ALU_MUL_EN
  task automatic check_mul(input logic [W-1:0] mp, input logic [W-1:0] mq,
                           input logic [W-1:0] er, input logic ec);
    out_ready = 1'b1;
    op(3'b111, mp, mq);
    for (int i = 0; i < W; i++) begin
      vectors++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        errors++;
        $display("FAIL mul_busy cycle=%0d got %b expected 100", i, {busy, in_ready, out_valid});
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({out_valid, busy, result, c} !== {2'b10, er, ec}) begin
      errors++;
      $display("FAIL mul_result got %h expected %h", {out_valid, busy, result, c}, {2'b10, er, ec});
    end
  endtask

  task automatic test_mul();
    check_mul(8'd13, 8'd12, 8'h9C, 1'b0);
    check_mul(8'd20, 8'd20, 8'h90, 1'b1);
  endtask

  task automatic test_mul_reset();
    out_ready = 1'b1;
    op(3'b111, 8'd5, 8'd9);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, result, z, c, n, v} !== '0) begin
      errors++;
      $display("FAIL mul_reset got %h expected 0", {out_valid, busy, result, z, c, n, v});
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_reset_ready got %b expected 1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mul_reset_stale got out_valid=%b expected 0", out_valid);
      end
    end
  endtask
`else
  task automatic test_mul_disabled();
    out_ready = 1'b1;
    op(3'b111, 8'h5A, 8'h33);
    vectors++;
    if ({out_valid, busy, result, z, c, n, v} !== {2'b10, 8'h00, 4'b1000}) begin
      errors++;
      $display("FAIL mul_disabled got %h expected %h", {out_valid, busy, result, z, c, n, v},
               {2'b10, 8'h00, 4'b1000});
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      func      = 3'($urandom_range(0, 7));
      p         = W'($urandom);
      q         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
`ifndef ALU_MUL_EN
      vectors++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL random_busy got %b expected 0", busy);
      end
`endif
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain();
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_dec_inc_wrap();
    test_backpressure();
    test_back_to_back();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    test_random();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/patp_alu_seq.md
Name: patp_alu_seq

Overview:
- Parametrised, registered successor to the PATP core ALU.
- Adds a width parameter, an extended 3-bit op set, and a registered flag set (z, c, n, v).
- Uses a valid/ready handshake on both sides, plus an optional multi-cycle shift-and-add multiply.
- Sits between the PATP decode stage and the accumulator/register write-back.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request this cycle.
- func  input  3  operation select.
- p  input  WIDTH  operand p.
- q  input  WIDTH  operand q.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- z  output  1  zero flag.
- c  output  1  carry/borrow flag.
- n  output  1  negative flag (result MSB).
- v  output  1  signed-overflow flag.
- busy  output  1  high while in the MUL state.

Behaviour:
- Clock/reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, result=0, z=c=n=v=0, busy=0, counter=0, internal multiply registers=0.
- Reset mid-multiply aborts the operation; no result is ever emitted for it.

Op set (all arithmetic modulo 2^WIDTH; p and q treated as two's complement for v):
- 000 clear: result=0.
- 001 inc: q+1.
- 010 add: q+p.
- 011 dec: q-1.
- 100 sub: q-p.
- 101 and: q&p.
- 110 xor: q^p.
- 111 mul: low WIDTH bits of q*p (unsigned), only when ALU_MUL_EN is defined.

Flags (computed from the final result, loaded together with it):
- z = (result==0).
- n = result[WIDTH-1].
- c:
  - add/inc: carry out.
  - sub/dec: borrow (sub: q<p unsigned; dec: q==0).
  - mul: 1 if the upper product half is nonzero.
  - clear/and/xor: 0.
- v:
  - add: sign(q)==sign(p) and sign(result)!=sign(q).
  - sub: sign(q)!=sign(p) and sign(result)!=sign(q).
  - inc: q==0111..1.
  - dec: q==1000..0.
  - all others: 0.

Handshake:
- Transfer occurs on a rising edge with in_valid&&in_ready. p, q and func are sampled only at that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational and permits back-to-back single-cycle ops at throughput 1.
- out_valid, result and flags hold stable until out_valid&&out_ready.
- On a completion edge with no new result: out_valid drops to 0; result and flags hold their last value.
- Simultaneous out_ready and new accept: the new result replaces the old on the same edge and out_valid stays 1.

Single-cycle ops (000–110):
- Accepted at edge k → result, flags and out_valid=1 registered at edge k.
- Visible in the cycle after edge k (latency 1).

State machine:
- IDLE → MUL on accept of func=111 (when ALU_MUL_EN is defined).
- In MUL: busy=1, in_ready=0. Each cycle processes one multiplier bit (LSB-first shift-and-add into a 2*WIDTH accumulator); the counter is loaded with WIDTH and decrements.
- MUL → IDLE on the edge where the counter reaches 0. On that edge, result, flags and out_valid=1 are loaded.
- Mul accepted at edge k → out_valid rises at edge k+WIDTH.
- MUL is entered only when out_valid==0 or the prior result is consumed on the accept edge (guaranteed by in_ready).

Unknown/disabled func: treated as clear (result=0, z=1, c=v=n=0), single-cycle.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: func=111 performs the multi-cycle multiply described above; the MUL state, counter and 2*WIDTH accumulator are instantiated.
- Undefined: no MUL state or multiply logic; busy tied to 0; func=111 behaves as clear, single-cycle.

Test Plan:
- WIDTH=8, func=010, q=8'h7F, p=8'h01, out_ready=1 → next cycle result=8'h80, z=0, c=0, n=1, v=1, out_valid=1.
- func=011, q=8'h00 → result=8'hFF, c=1 (borrow), n=1, v=0. Then func=001, q=8'hFF → result=8'h00, z=1, c=1.
- out_ready=0 after result 8'h05; apply in_valid with func=001, q=8'h10 → in_ready=0; result stays 8'h05 until out_ready=1. Next op is accepted on the consume edge; 8'h11 appears the following cycle.
- ALU_MUL_EN defined, func=111, q=8'd12, p=8'd13, accept at edge k → busy=1 and in_ready=0 for 8 cycles; out_valid at edge k+8 with result=8'h9C, c=0.
  - Repeat with q=8'd20, p=8'd20 → result=8'h90, c=1.
- Assert rst_n=0 asynchronously 3 cycles into a multiply → out_valid, busy, result and flags go to 0 immediately; after release, in_ready=1 and no stale result appears.
- ALU_MUL_EN undefined, func=111, q=8'h33 → one cycle later result=8'h00, z=1, busy never asserted.
